// File: rtl/dmem_access_ctrl.sv
// MEM-stage data memory access sequencer.
// Issues req/ready handshakes, stalls the pipe and bubbles MEM/WB.
module dmem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ex_mem_read,
  input  logic             ex_mem_write,
  input  logic [31:0]      ex_addr,
  input  logic [31:0]      ex_wdata,
  input  logic             flush,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [31:0]      dmem_addr,
  output logic [31:0]      dmem_wdata,
  input  logic             dmem_ready,
  input  logic [31:0]      dmem_rdata,
  output logic [31:0]      read_data_out,
  output logic             pipe_stall,
  output logic             wb_bubble,
  output logic             bus_error,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             we_q, we_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             access;
  logic             idle_acc;

  assign access   = (ex_mem_read | ex_mem_write) & ~flush;
  assign idle_acc = (state_q == S_IDLE) & access;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    tcnt_d  = tcnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (access) begin
          state_d = S_WAIT;
          addr_d  = ex_addr;
          wdata_d = ex_wdata;
          we_d    = ex_mem_write;
          tcnt_d  = '0;
        end
      end
      S_WAIT: begin
        tcnt_d = tcnt_q + 1'b1;
        // ready wins over a timeout landing on the same cycle
        if (dmem_ready) begin
          state_d = S_DONE;
          if (!we_q) rdata_d = dmem_rdata;
        end else if (tcnt_q == TLAST) begin
          state_d = S_ERR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign pipe_stall = idle_acc | (state_q == S_WAIT);
  assign wb_bubble  = pipe_stall | (state_q == S_ERR);

  always_comb begin
    stall_d = stall_q;
    if (pipe_stall && (stall_q != '1)) stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      tcnt_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      tcnt_q  <= tcnt_d;
      stall_q <= stall_d;
    end
  end

  assign dmem_req      = (state_q == S_WAIT);
  assign bus_error     = (state_q == S_ERR);
  assign dmem_we       = we_q;
  assign dmem_addr     = addr_q;
  assign dmem_wdata    = wdata_q;
  assign read_data_out = rdata_q;
  assign stall_cycles  = stall_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: vector table plus scoreboard queue,
// with hand-written reset-mid-access sequence.
module tb_dmem_access_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        ex_mem_read, ex_mem_write, flush;
  logic [31:0] ex_addr, ex_wdata;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, read_data_out;
  logic        pipe_stall, wb_bubble, bus_error;
  logic [31:0] stall_cycles;

  dmem_access_ctrl #(
    .TIMEOUT_CYCLES(16),
    .CNT_W(32)
  ) dut (
    .clock(clock),
    .reset(reset),
    .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write),
    .ex_addr(ex_addr),
    .ex_wdata(ex_wdata),
    .flush(flush),
    .dmem_req(dmem_req),
    .dmem_we(dmem_we),
    .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata),
    .read_data_out(read_data_out),
    .pipe_stall(pipe_stall),
    .wb_bubble(wb_bubble),
    .bus_error(bus_error),
    .stall_cycles(stall_cycles)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rd;
    logic        wr;
    logic        fl;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
    logic        access;
    logic        we;
    logic        err;
    int          waits;
    int          stall_inc;
    logic [31:0] rdo;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] rdo;
    int          stall;
  } exp_t;

  vec_t tbl[9];
  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_stall = 0;
  int   exp_pulses = 0;
  int   req_pulses = 0;
  logic req_prev = 1'b0;

  always @(negedge clock) begin
    if (dmem_req && !req_prev) req_pulses++;
    req_prev = dmem_req;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    ex_mem_read  = v.rd;
    ex_mem_write = v.wr;
    flush        = v.fl;
    ex_addr      = v.addr;
    ex_wdata     = v.wdata;
    dmem_ready   = 1'b0;
    dmem_rdata   = 32'h0;
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    @(negedge clock);
    drive(v);
    #1;
    chk("idle_stall", {31'b0, pipe_stall}, {31'b0, v.access});
    chk("idle_bubble", {31'b0, wb_bubble}, {31'b0, v.access});
    chk("idle_req", {31'b0, dmem_req}, 32'd0);
    if (!v.access) begin
      chk("pass_cnt", stall_cycles, exp_stall);
      return;
    end
    exp_pulses++;
    exp_stall += v.stall_inc;
    sbq.push_back('{v.err, v.rdo, exp_stall});
    for (int k = 0; k < v.waits; k++) begin
      @(negedge clock);
      dmem_ready = (v.delay == k + 1);
      dmem_rdata = v.rdata;
      #1;
      chk("wait_req", {31'b0, dmem_req}, 32'd1);
      chk("wait_we", {31'b0, dmem_we}, {31'b0, v.we});
      chk("wait_addr", dmem_addr, v.addr);
      chk("wait_wdata", dmem_wdata, v.wdata);
      chk("wait_stall", {31'b0, pipe_stall}, 32'd1);
    end
    @(negedge clock);
    dmem_ready = 1'b0;
    #1;
    e = sbq.pop_front();
    chk("end_req", {31'b0, dmem_req}, 32'd0);
    chk("end_stall", {31'b0, pipe_stall}, 32'd0);
    chk("end_bubble", {31'b0, wb_bubble}, {31'b0, e.err});
    chk("end_buserr", {31'b0, bus_error}, {31'b0, e.err});
    chk("end_rdata", read_data_out, e.rdo);
    chk("end_cnt", stall_cycles, e.stall);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1, 0, 0, 32'h40, 32'h0, 32'hDEADBEEF, 1,
               1, 0, 0, 1, 2, 32'hDEADBEEF};
    tbl[1] = '{0, 1, 0, 32'h80, 32'h1234, 32'hFFFF0000, 4,
               1, 1, 0, 4, 5, 32'hDEADBEEF};
    tbl[2] = '{1, 0, 0, 32'h44, 32'h0, 32'h11111111, 0,
               1, 0, 1, 16, 17, 32'hDEADBEEF};
    tbl[3] = '{1, 0, 0, 32'h100, 32'h0, 32'h0000000A, 1,
               1, 0, 0, 1, 2, 32'h0000000A};
    tbl[4] = '{1, 0, 0, 32'h104, 32'h0, 32'h0000000B, 1,
               1, 0, 0, 1, 2, 32'h0000000B};
    tbl[5] = '{1, 0, 1, 32'h108, 32'h0, 32'h0, 0,
               0, 0, 0, 0, 0, 32'h0000000B};
    tbl[6] = '{0, 0, 0, 32'h10C, 32'h0, 32'h0, 0,
               0, 0, 0, 0, 0, 32'h0000000B};
    tbl[7] = '{1, 1, 0, 32'h110, 32'hA5A5A5A5, 32'h77777777, 2,
               1, 1, 0, 2, 3, 32'h0000000B};
    tbl[8] = '{1, 0, 0, 32'h114, 32'h0, 32'h55555555, 16,
               1, 0, 0, 16, 17, 32'h55555555};

    reset        = 1'b0;
    ex_mem_read  = 1'b0;
    ex_mem_write = 1'b0;
    flush        = 1'b0;
    ex_addr      = 32'h0;
    ex_wdata     = 32'h0;
    dmem_ready   = 1'b0;
    dmem_rdata   = 32'h0;
    #2;
    chk("rst_req", {31'b0, dmem_req}, 32'd0);
    chk("rst_we", {31'b0, dmem_we}, 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_rdata", read_data_out, 32'd0);
    chk("rst_buserr", {31'b0, bus_error}, 32'd0);
    chk("rst_cnt", stall_cycles, 32'd0);
    chk("rst_stall", {31'b0, pipe_stall}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(tbl[i]);

    @(negedge clock);
    ex_mem_read = 1'b1;
    ex_addr     = 32'h200;
    @(negedge clock);
    #1;
    chk("mid_req", {31'b0, dmem_req}, 32'd1);
    exp_pulses++;
    #2;
    reset = 1'b0;
    #1;
    chk("arst_req", {31'b0, dmem_req}, 32'd0);
    chk("arst_addr", dmem_addr, 32'd0);
    chk("arst_rdata", read_data_out, 32'd0);
    chk("arst_buserr", {31'b0, bus_error}, 32'd0);
    chk("arst_cnt", stall_cycles, 32'd0);
    ex_mem_read = 1'b0;
    exp_stall   = 0;
    @(negedge clock);
    reset = 1'b1;
    run_vec('{1, 0, 0, 32'h300, 32'h0, 32'hCAFEF00D, 2,
              1, 0, 0, 2, 3, 32'hCAFEF00D});

    @(negedge clock);
    ex_mem_read = 1'b0;
    @(negedge clock);
    #1;
    chk("req_pulses", req_pulses, exp_pulses);
    chk("sb_empty", sbq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
